// File: rtl/xlr8_pcint_pkg.sv
// -----------------------------------------------------------------------------
// xlr8_pcint_pkg
// Shared definitions for the pin-change interrupt controller:
//   - handshake FSM state type
//   - default PCICR / PCIFR register addresses
//   - data-memory mapping threshold and the port-count ceiling
//   - helper that classifies a register address as DM- or I/O-mapped
// No ports (package).
// -----------------------------------------------------------------------------
package xlr8_pcint_pkg;

  localparam int         MAX_PORTS      = 8;
  localparam logic [7:0] DM_THRESHOLD   = 8'h60;
  localparam logic [7:0] PCICR_DEF_ADDR = 8'h68;
  localparam logic [7:0] PCIFR_DEF_ADDR = 8'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } pcint_state_e;

  // Addresses at or above the threshold live in data memory, below it in I/O.
  function automatic logic is_dm_mapped(input logic [7:0] addr);
    return addr >= DM_THRESHOLD;
  endfunction

endpackage

// File: rtl/xlr8_pcint_arb.sv
// -----------------------------------------------------------------------------
// xlr8_pcint_arb
// Fixed-priority picker (lowest index wins) feeding a one-hot grant register.
// The grant only changes when load is asserted, so it stays stable for the
// whole life of a request.
// Ports:
//   clk    in   core clock
//   rst    in   synchronous reset, active-high
//   load   in   capture the current pick into the grant register
//   req    in   NUM_PORTS pending request vector
//   grant  out  NUM_PORTS one-hot registered grant (0 after reset)
// -----------------------------------------------------------------------------
module xlr8_pcint_arb
  import xlr8_pcint_pkg::*;
#(
  parameter int NUM_PORTS = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [NUM_PORTS-1:0] req,
  output logic [NUM_PORTS-1:0] grant
);

  logic [NUM_PORTS-1:0] pick;

  // Two's-complement trick isolates the lowest set bit.
  assign pick = req & (~req + NUM_PORTS'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      grant <= '0;
    end else if (load) begin
      grant <= pick;
    end
  end

endmodule

// File: rtl/xlr8_pcint_ctrl.sv
// -----------------------------------------------------------------------------
// xlr8_pcint_ctrl
// Pin-change interrupt controller above the per-port GPIO blocks. Captures
// each port's pin-change event into a PCIFR flag, gates flags with PCICR
// enables and presents one pending port at a time to the core through a
// request/acknowledge handshake. Owns PCICR and PCIFR on the I/O / DM bus.
//
// Build option: define XLR8_PCINT_GLITCH_FILTER_EN to require pcifr_set to be
// high for two consecutive cycles before a flag sets (one extra cycle of
// latency, single-cycle pulses ignored). Undefined: raw rising edge.
//
// Ports:
//   clk, rst            core clock, synchronous active-high reset
//   clken               register-write qualifier
//   adr, iore, iowe     I/O address and strobes
//   ramadr, ramre,
//   ramwe, dm_sel       data-memory address, strobes and select
//   dbus_in / dbus_out  write data / combinational read data
//   io_out_en           read-data valid
//   pcifr_set           per-port pin-change event level
//   pc_irq              one-hot interrupt request to the core
//   pc_irq_ack          per-port acknowledge from the core
//   pcint_active        high while a request is outstanding (REQ or HOLD)
// -----------------------------------------------------------------------------
module xlr8_pcint_ctrl
  import xlr8_pcint_pkg::*;
#(
  parameter int         NUM_PORTS     = 3,
  parameter logic [7:0] PCICR_ADDR    = PCICR_DEF_ADDR,
  parameter logic [7:0] PCIFR_ADDR    = PCIFR_DEF_ADDR,
  parameter logic [7:0] PCICR_RST_VAL = 8'h00
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clken,
  input  logic [5:0]           adr,
  input  logic [7:0]           dbus_in,
  output logic [7:0]           dbus_out,
  input  logic                 iore,
  input  logic                 iowe,
  output logic                 io_out_en,
  input  logic [7:0]           ramadr,
  input  logic                 ramre,
  input  logic                 ramwe,
  input  logic                 dm_sel,
  input  logic [NUM_PORTS-1:0] pcifr_set,
  output logic [NUM_PORTS-1:0] pc_irq,
  input  logic [NUM_PORTS-1:0] pc_irq_ack,
  output logic                 pcint_active
);

  localparam logic CR_DM = is_dm_mapped(PCICR_ADDR);
  localparam logic FR_DM = is_dm_mapped(PCIFR_ADDR);

  // ---------------------------------------------------------------------------
  // Register decode
  // ---------------------------------------------------------------------------
  logic pcicr_sel, pcicr_re, pcicr_we;
  logic pcifr_sel, pcifr_re, pcifr_we;

  assign pcicr_sel = CR_DM ? (dm_sel && (ramadr == PCICR_ADDR))
                           : (adr == PCICR_ADDR[5:0]);
  assign pcifr_sel = FR_DM ? (dm_sel && (ramadr == PCIFR_ADDR))
                           : (adr == PCIFR_ADDR[5:0]);

  assign pcicr_re = pcicr_sel && (CR_DM ? ramre : iore);
  assign pcicr_we = pcicr_sel && (CR_DM ? ramwe : iowe);
  assign pcifr_re = pcifr_sel && (FR_DM ? ramre : iore);
  assign pcifr_we = pcifr_sel && (FR_DM ? ramwe : iowe);

  // Upper data bits are only meaningful when all eight ports are present.
  if (NUM_PORTS < MAX_PORTS) begin : g_unused
    logic unused_dbus_hi;
    assign unused_dbus_hi = ^dbus_in[7:NUM_PORTS];
  end

  // ---------------------------------------------------------------------------
  // PCICR
  // ---------------------------------------------------------------------------
  logic [NUM_PORTS-1:0] pcicr;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours; blocking here would create
  // order-dependent simulation races.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcicr <= PCICR_RST_VAL[NUM_PORTS-1:0];
    end else if (clken && pcicr_we) begin
      pcicr <= dbus_in[NUM_PORTS-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Pin-change event detection
  // ---------------------------------------------------------------------------
  logic [NUM_PORTS-1:0] set_vec;

`ifdef XLR8_PCINT_GLITCH_FILTER_EN
  // lvl_q holds last cycle's level; filt_q is the "high for two cycles"
  // level as seen one cycle ago, so set fires on its rising edge.
  logic [NUM_PORTS-1:0] lvl_q, filt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lvl_q  <= '0;
      filt_q <= '0;
    end else begin
      lvl_q  <= pcifr_set;
      filt_q <= pcifr_set & lvl_q;
    end
  end

  assign set_vec = pcifr_set & lvl_q & ~filt_q;
`else
  logic [NUM_PORTS-1:0] prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= '0;
    end else begin
      prev_q <= pcifr_set;
    end
  end

  assign set_vec = pcifr_set & ~prev_q;
`endif

  // ---------------------------------------------------------------------------
  // PCIFR flags: set beats clear so an event arriving during a clear survives.
  // ---------------------------------------------------------------------------
  logic [NUM_PORTS-1:0] pcifr, clr_vec, pending;

  assign clr_vec = ((clken && pcifr_we) ? dbus_in[NUM_PORTS-1:0] : '0)
                 | (pc_irq_ack & pc_irq);

  always_ff @(posedge clk) begin
    if (rst) begin
      pcifr <= '0;
    end else begin
      pcifr <= set_vec | (pcifr & ~clr_vec);
    end
  end

  assign pending = pcifr & pcicr;

  // ---------------------------------------------------------------------------
  // Read path (combinational, zero latency)
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before any conditional
  // assignment; a path that leaves it unassigned would infer a latch.
  always_comb begin
    dbus_out = '0;
    if (pcicr_re) dbus_out = dbus_out | 8'(pcicr);
    if (pcifr_re) dbus_out = dbus_out | 8'(pcifr);
  end

  assign io_out_en = pcicr_re || pcifr_re;

  // ---------------------------------------------------------------------------
  // Handshake FSM
  // ---------------------------------------------------------------------------
  pcint_state_e         state, state_nxt;
  logic                 grant_load;
  logic [NUM_PORTS-1:0] grant;

  xlr8_pcint_arb #(
    .NUM_PORTS (NUM_PORTS)
  ) u_arb (
    .clk   (clk),
    .rst   (rst),
    .load  (grant_load),
    .req   (pending),
    .grant (grant)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    grant_load = 1'b0;
    unique case (state)
      IDLE: begin
        if (|pending) begin
          grant_load = 1'b1;
          state_nxt  = REQ;
        end
      end
      REQ: begin
        if (|(pc_irq_ack & grant)) begin
          state_nxt = HOLD;
        end else if (!(|(pending & grant))) begin
          state_nxt = IDLE;
        end
      end
      HOLD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The request is masked by pending so a software clear or disable withdraws
  // it immediately; the FSM then returns to IDLE on the following edge.
  always_comb begin
    pc_irq       = '0;
    pcint_active = 1'b0;
    unique case (state)
      REQ: begin
        pc_irq       = grant & pending;
        pcint_active = 1'b1;
      end
      HOLD:    pcint_active = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_xlr8_pcint_ctrl.sv
// -----------------------------------------------------------------------------
// tb_xlr8_pcint_ctrl
// Self-checking bench for xlr8_pcint_ctrl (NUM_PORTS=3, PCICR_RST_VAL=1,
// default addresses: PCICR DM-mapped at 8'h68, PCIFR I/O-mapped at 6'h1B).
// A behavioural model tracks flags, enables and the outstanding grant; all
// outputs are compared every cycle, with directed checks at key points.
// -----------------------------------------------------------------------------
module tb_xlr8_pcint_ctrl;

  localparam int N = 3;

  logic         clk = 1'b0;
  logic         rst, clken;
  logic [5:0]   adr;
  logic [7:0]   dbus_in, dbus_out;
  logic         iore, iowe, io_out_en;
  logic [7:0]   ramadr;
  logic         ramre, ramwe, dm_sel;
  logic [N-1:0] pcifr_set, pc_irq, pc_irq_ack;
  logic         pcint_active;

  always #5 clk = ~clk;

  xlr8_pcint_ctrl #(
    .NUM_PORTS     (N),
    .PCICR_RST_VAL (8'h01)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clken        (clken),
    .adr          (adr),
    .dbus_in      (dbus_in),
    .dbus_out     (dbus_out),
    .iore         (iore),
    .iowe         (iowe),
    .io_out_en    (io_out_en),
    .ramadr       (ramadr),
    .ramre        (ramre),
    .ramwe        (ramwe),
    .dm_sel       (dm_sel),
    .pcifr_set    (pcifr_set),
    .pc_irq       (pc_irq),
    .pc_irq_ack   (pc_irq_ack),
    .pcint_active (pcint_active)
  );

  int n_checks = 0;
  int n_fails  = 0;

  // ---------------- reference model ----------------
  bit [N-1:0] m_flags, m_pcicr, h1, h2;
  int         m_grant = -1;   // port currently requested, -1 when none
  bit         m_cool  = 1'b0; // one-cycle holdoff after an acknowledge

  function automatic bit [N-1:0] exp_irq();
    bit [N-1:0] one = 1;
    if (m_grant >= 0 && m_flags[m_grant] && m_pcicr[m_grant]) return one << m_grant;
    return '0;
  endfunction

  function automatic bit exp_active();
    return (m_grant >= 0) || m_cool;
  endfunction

  function automatic bit exp_rd_cr();
    return dm_sel && ramre && (ramadr == 8'h68);
  endfunction

  function automatic bit exp_rd_fr();
    return iore && (adr == 6'h1B);
  endfunction

  function automatic bit [7:0] exp_rdata();
    bit [7:0] r = 8'h00;
    if (exp_rd_cr()) r = r | 8'(m_pcicr);
    if (exp_rd_fr()) r = r | 8'(m_flags);
    return r;
  endfunction

  task automatic model_advance();
    bit [N-1:0] pend, irq, setv, clrv;
    bit         cr_we, fr_we;
    pend  = m_flags & m_pcicr;
    irq   = exp_irq();
    cr_we = clken && dm_sel && ramwe && (ramadr == 8'h68);
    fr_we = clken && iowe && (adr == 6'h1B);
`ifdef XLR8_PCINT_GLITCH_FILTER_EN
    setv = (pcifr_set & h1) & ~(h1 & h2);
`else
    setv = pcifr_set & ~h1;
`endif
    clrv = (fr_we ? dbus_in[N-1:0] : '0) | (pc_irq_ack & irq);
    if (rst) begin
      m_flags = '0; m_pcicr = 3'b001; m_grant = -1; m_cool = 0; h1 = '0; h2 = '0;
      return;
    end
    if (m_cool) m_cool = 0;
    else if (m_grant < 0) begin
      for (int i = N - 1; i >= 0; i--) if (pend[i]) m_grant = i;
    end else if (pc_irq_ack[m_grant]) begin
      m_grant = -1; m_cool = 1;
    end else if (!pend[m_grant]) m_grant = -1;
    m_flags = setv | (m_flags & ~clrv);
    if (cr_we) m_pcicr = dbus_in[N-1:0];
    h2 = h1;
    h1 = pcifr_set;
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit cmp = 1'b1);
    #1;
    if (cmp) begin
      check("cyc_pc_irq", 8'(pc_irq), 8'(exp_irq()));
      check("cyc_active", 8'(pcint_active), 8'(exp_active()));
      check("cyc_dbus_out", dbus_out, exp_rdata());
      check("cyc_io_out_en", 8'(io_out_en), 8'(exp_rd_cr() || exp_rd_fr()));
    end
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    clken = 1; adr = 6'h00; dbus_in = 8'h00; iore = 0; iowe = 0;
    ramadr = 8'h00; ramre = 0; ramwe = 0; dm_sel = 0;
  endtask

  task automatic wr_pcicr(input logic [7:0] v);
    idle_bus(); dm_sel = 1; ramadr = 8'h68; ramwe = 1; dbus_in = v;
    cycle();
    idle_bus();
  endtask

  task automatic wr_pcifr(input logic [7:0] v);
    idle_bus(); adr = 6'h1B; iowe = 1; dbus_in = v;
    cycle();
    idle_bus();
  endtask

  task automatic rd_pcifr(input string tag, input logic [7:0] exp);
    idle_bus(); adr = 6'h1B; iore = 1;
    #1;
    check(tag, dbus_out, exp);
    check({tag, "_en"}, 8'(io_out_en), 8'h01);
    idle_bus();
  endtask

  task automatic rd_pcicr(input string tag, input logic [7:0] exp);
    idle_bus(); dm_sel = 1; ramadr = 8'h68; ramre = 1;
    #1;
    check(tag, dbus_out, exp);
    check({tag, "_en"}, 8'(io_out_en), 8'h01);
    idle_bus();
  endtask

  task automatic wait_irq(input string tag, input logic [7:0] exp);
    for (int k = 0; k < 8 && pc_irq == '0; k++) cycle();
    check(tag, 8'(pc_irq), exp);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1; pc_irq_ack = '0; pcifr_set = '0;
    idle_bus();
    cycle(1'b0);
    cycle(1'b0);
    rst = 0;

    // Reset state
    check("rst_pc_irq", 8'(pc_irq), 8'h00);
    check("rst_active", 8'(pcint_active), 8'h00);
    rd_pcicr("rst_pcicr", 8'h01);
    rd_pcifr("rst_pcifr", 8'h00);

    // Flag sets without enable; enabling later raises the request
    pcifr_set = 3'b010;
    cycle(); cycle();
    rd_pcifr("flag1_set", 8'h02);
    check("flag1_no_irq", 8'(pc_irq), 8'h00);
    wr_pcicr(8'h02);
    cycle(); cycle();
    check("en1_irq", 8'(pc_irq), 8'h02);
    pc_irq_ack = 3'b010; cycle(); pc_irq_ack = '0;
    cycle(); cycle();

    // Simultaneous events: lowest index first, holdoff, then the next one
    wr_pcicr(8'h07);
    pcifr_set = 3'b101;
    wait_irq("prio_first", 8'h01);
    pc_irq_ack = 3'b001; cycle(); pc_irq_ack = '0;
    check("hold_irq", 8'(pc_irq), 8'h00);
    check("hold_active", 8'(pcint_active), 8'h01);
    cycle();
    check("idle_active", 8'(pcint_active), 8'h00);
    cycle();
    check("prio_second", 8'(pc_irq), 8'h04);
    pc_irq_ack = 3'b100; cycle(); pc_irq_ack = '0;
    cycle(); cycle();

    // Software clear withdraws an outstanding request
    pcifr_set = 3'b111;
    wait_irq("wd_irq", 8'h02);
    wr_pcifr(8'h02);
    check("wd_irq_drop", 8'(pc_irq), 8'h00);
    cycle();
    check("wd_idle", 8'(pcint_active), 8'h00);

    // Set beats clear in the same cycle
    wr_pcicr(8'h00);
    pcifr_set = 3'b000;
    cycle(); cycle(); cycle();
    pcifr_set = 3'b001;
`ifdef XLR8_PCINT_GLITCH_FILTER_EN
    cycle();
`endif
    wr_pcifr(8'h01);
    cycle();
    rd_pcifr("set_beats_clr", 8'h01);

    // Reads: I/O, DM, wrong select, both at once
    pcifr_set = 3'b101;
    cycle(); cycle(); cycle();
    rd_pcifr("io_rd_pcifr", 8'h05);
    wr_pcicr(8'h06);
    rd_pcicr("dm_rd_pcicr", 8'h06);
    ramadr = 8'h68; ramre = 1; dm_sel = 0;
    #1;
    check("dm_nosel_data", dbus_out, 8'h00);
    check("dm_nosel_en", 8'(io_out_en), 8'h00);
    dm_sel = 1; adr = 6'h1B; iore = 1;
    #1;
    check("both_rd_or", dbus_out, 8'h07);
    idle_bus();

    // Reset while a request is outstanding
    wait_irq("pre_rst_irq", 8'h04);
    rst = 1; pcifr_set = '0; cycle(); rst = 0;
    check("rst_mid_irq", 8'(pc_irq), 8'h00);
    check("rst_mid_active", 8'(pcint_active), 8'h00);
    rd_pcifr("rst_mid_pcifr", 8'h00);
    rd_pcicr("rst_mid_pcicr", 8'h01);

    // Single-cycle pulse
    pcifr_set = 3'b001; cycle(); pcifr_set = 3'b000;
    cycle(); cycle(); cycle();
`ifdef XLR8_PCINT_GLITCH_FILTER_EN
    rd_pcifr("glitch_pulse", 8'h00);
`else
    rd_pcifr("glitch_pulse", 8'h01);
`endif
    wr_pcifr(8'hFF);
    cycle(); cycle();

    // Randomised traffic against the model
    for (int t = 0; t < 600; t++) begin
      idle_bus();
      rst   = ($urandom_range(0, 149) == 0);
      clken = ($urandom_range(0, 7) != 0);
      for (int b = 0; b < N; b++) if ($urandom_range(0, 3) == 0) pcifr_set[b] = ~pcifr_set[b];
      case ($urandom_range(0, 9))
        0: begin dm_sel = 1; ramadr = 8'h68; ramwe = 1; dbus_in = 8'($urandom); end
        1: begin adr = 6'h1B; iowe = 1; dbus_in = 8'($urandom); end
        2: begin dm_sel = 1; ramadr = 8'h68; ramre = 1; end
        3: begin adr = 6'h1B; iore = 1; end
        4: begin dm_sel = $urandom_range(0, 1); ramadr = 8'($urandom); ramre = 1; ramwe = 1;
                 adr = 6'($urandom); iore = 1; iowe = 1; dbus_in = 8'($urandom); end
        default: ;
      endcase
      if ($urandom_range(0, 2) == 0) pc_irq_ack = exp_irq();
      else if ($urandom_range(0, 7) == 0) pc_irq_ack = N'($urandom);
      else pc_irq_ack = '0;
      cycle();
    end
    rst = 0; pc_irq_ack = '0; idle_bus();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
